fft_input_loader: RTL
=====================

// Module: fft_input_loader
// PURPOSE
//  Input-side counterpart of the FFT output merge. Accepts a serial stream of complex
//  samples, buffers one frame of N = 8/16/32 points and presents it as parallel lanes
//  X_k to the FFT8/FFT16/FFT32 cores, then fires a one-cycle start to the selected
//  core. Waits for that core's done before loading the next frame.
// PARAMETERS
//  DATA_W  16  width of each real/imag sample
//  MAX_N   32  buffer depth in complex points; fixed, sized for the largest core
// PORTS
//  clk_i           in   1             clock, rising edge
//  rst_n_i         in   1             asynchronous active-low reset
//  fft_select_i    in   2             0=FFT8, 1=FFT16, 2=FFT32, 3=reserved
//  s_R_i           in   DATA_W        input sample, real part
//  s_I_i           in   DATA_W        input sample, imaginary part
//  s_valid_i       in   1             input sample valid
//  s_ready_o       out  1             loader can accept a sample
//  fft_done_i      in   1             OR of the core valids (merge valid_o)
//  X_R_o           out  MAX_N*DATA_W  lane k real part, bits [k*DATA_W +: DATA_W]
//  X_I_o           out  MAX_N*DATA_W  lane k imaginary part, same packing
//  start_fft8_o    out  1             one-cycle start for the FFT8 core
//  start_fft16_o   out  1             one-cycle start for the FFT16 core
//  start_fft32_o   out  1             one-cycle start for the FFT32 core
//  busy_o          out  1             high from FIRE through WAIT
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, sel_q=0, buffer=0. All outputs are 0, except s_ready_o,
//    which is 1 in IDLE whenever fft_select_i!=3.
//  - Handshake: a sample is accepted when s_valid_i && s_ready_o on a rising edge.
//    s_ready_o = (IDLE && fft_select_i!=3) || LOAD. It is combinational from state.
//  - IDLE: on an accept, latch sel_q=fft_select_i and N=8<<sel_q. Write buf[0]. Set cnt=1.
//    Go to LOAD, or go to FIRE when N==1 (not possible). fft_select_i is ignored outside IDLE.
//  - LOAD: on each accept, write buf[cnt] and increment cnt. The accept with cnt==N-1 sets
//    cnt=0 and moves to FIRE. The last sample is visible on X_* in the FIRE cycle.
//    Gaps in s_valid_i are allowed and hold state.
//  - FIRE (one cycle): start_fftX_o=1 for sel_q only. busy_o=1. s_ready_o=0. Next state is WAIT.
//  - WAIT: s_ready_o=0. When fft_done_i=1, go to IDLE. fft_done_i is ignored in IDLE, LOAD
//    and FIRE. Latency from the last accepted sample to start is 1 cycle.
//  - Lane gating: X_*[k] = buf[k] for k<N, else 0. Unused lanes stay zero so the downstream
//    OR-merge stays clean. X_* is stable from FIRE until the next frame's first accept.
//  - Back-to-back frames: a new frame may start in the cycle after WAIT->IDLE.
//    Throughput is N + 1 + core latency cycles per frame.
//  - Reset mid-frame: the partial frame is discarded. Outputs return to reset values
//    asynchronously. No start is issued.
//  - start_* outputs are registered. At most one is high in any cycle.
// CONFIGURATION
//  BIT_REVERSE_EN defined:
//    - Sample n is written to buf[bitrev_log2N(n)], i.e. reversed over 3/4/5 bits for N=8/16/32.
//    - Cores then receive decimation-in-time input order.
//  BIT_REVERSE_EN undefined:
//    - Natural order, buf[n].
//    - Handshake and timing are identical in both builds.
// TESTING
//  1 Reset: rst_n_i=0 mid-LOAD (cnt=5, sel=2)
//    -> all X_* =0, start_*=0, busy_o=0.
//    -> After release, a fresh 32-sample frame loads correctly.
//  2 FFT8: sel=0, samples R=n+1, I=-(n+1), n=0..7, continuous valid
//    -> start_fft8_o pulses 1 cycle after the 8th accept.
//    -> Lane k: R=k+1, I=-(k+1). Lanes 8..31 =0. s_ready_o=0 until fft_done_i.
//  3 FFT32 with gaps: sel=2, s_valid_i toggling 1/0, R=0x100+n
//    -> start_fft32_o only after the 32nd accept. Lane 31 R=0x11F. No start_fft8/16 activity.
//  4 Reserved/late select: sel=3 in IDLE -> s_ready_o=0, nothing accepted.
//    Then sel=1, load 16 samples, change sel to 0 mid-frame
//    -> still start_fft16_o, lanes 16..31 =0.
//  5 Done handling: fft_done_i=1 during LOAD and FIRE -> ignored.
//    In WAIT -> IDLE next cycle. The next frame's first sample is accepted in that cycle.
//  6 BIT_REVERSE_EN build: sel=0, R=n -> lanes R = {0,4,2,6,1,5,3,7}.
//    Same stimulus in the natural build -> {0..7}.

Source files
------------

// File: rtl/fft_input_loader.sv
// Serial-to-parallel frame loader feeding the FFT8/16/32 cores; fires a start pulse per frame.
// Optional BIT_REVERSE_EN: store samples in bit-reversed order (DIT input) instead of natural order.
module fft_input_loader #(
   parameter int DATA_W = 16,
   parameter int MAX_N  = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic [1:0]                fft_select_i,
   input  logic [DATA_W-1:0]         s_R_i,
   input  logic [DATA_W-1:0]         s_I_i,
   input  logic                      s_valid_i,
   output logic                      s_ready_o,
   input  logic                      fft_done_i,
   output logic [MAX_N*DATA_W-1:0]   X_R_o,
   output logic [MAX_N*DATA_W-1:0]   X_I_o,
   output logic                      start_fft8_o,
   output logic                      start_fft16_o,
   output logic                      start_fft32_o,
   output logic                      busy_o
);

   // MAX_N is fixed at 32 points, so the sample counter and lane index are 5 bits.
   localparam int CNT_W = 5;

   typedef enum logic [1:0] {IDLE, LOAD, FIRE, WAIT} state_t;

   state_t             state;
   state_t             state_next;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_next;
   logic [CNT_W-1:0]   last_idx;
   logic [CNT_W-1:0]   seq_idx;
   logic [CNT_W-1:0]   wr_idx;
   logic [1:0]         sel_q;
   logic [2:0]         start_q;
   logic [2:0]         start_next;
   logic               accept;
   int                 lane_count;

   logic [DATA_W-1:0]  mem_r [MAX_N];
   logic [DATA_W-1:0]  mem_i [MAX_N];

   assign s_ready_o = ((state == IDLE) && (fft_select_i != 2'd3)) || (state == LOAD);
   assign accept    = s_valid_i && s_ready_o;
   assign busy_o    = (state == FIRE) || (state == WAIT);

   assign start_fft8_o  = start_q[0];
   assign start_fft16_o = start_q[1];
   assign start_fft32_o = start_q[2];

   always_comb begin
      last_idx = CNT_W'(31);
      case (sel_q)
         2'd0:    last_idx = CNT_W'(7);
         2'd1:    last_idx = CNT_W'(15);
         default: last_idx = CNT_W'(31);
      endcase
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      start_next = 3'b000;
      case (state)
         IDLE: begin
            if (accept) begin
               cnt_next   = CNT_W'(1);
               state_next = LOAD;
            end
         end
         LOAD: begin
            if (accept) begin
               if (cnt == last_idx) begin
                  cnt_next   = '0;
                  state_next = FIRE;
               end else begin
                  cnt_next = cnt + CNT_W'(1);
               end
            end
         end
         FIRE: state_next = WAIT;
         WAIT: begin
            if (fft_done_i) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // Start is registered, so it is decoded from the state we are about to enter.
      if (state_next == FIRE) begin
         case (sel_q)
            2'd0:    start_next = 3'b001;
            2'd1:    start_next = 3'b010;
            2'd2:    start_next = 3'b100;
            default: start_next = 3'b000;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state   <= IDLE;
         cnt     <= '0;
         sel_q   <= 2'd0;
         start_q <= 3'b000;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         start_q <= start_next;
         if ((state == IDLE) && accept) sel_q <= fft_select_i;
      end
   end

   assign seq_idx = (state == IDLE) ? '0 : cnt;

`ifdef BIT_REVERSE_EN
   logic [1:0] sel_eff;
   assign sel_eff = (state == IDLE) ? fft_select_i : sel_q;

   always_comb begin
      wr_idx = seq_idx;
      case (sel_eff)
         2'd0:    wr_idx = {2'b00, seq_idx[0], seq_idx[1], seq_idx[2]};
         2'd1:    wr_idx = {1'b0, seq_idx[0], seq_idx[1], seq_idx[2], seq_idx[3]};
         default: wr_idx = {seq_idx[0], seq_idx[1], seq_idx[2], seq_idx[3], seq_idx[4]};
      endcase
   end
`else
   assign wr_idx = seq_idx;
`endif

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int k = 0; k < MAX_N; k++) begin
            mem_r[k] <= '0;
            mem_i[k] <= '0;
         end
      end else if (accept) begin
         mem_r[wr_idx] <= s_R_i;
         mem_i[wr_idx] <= s_I_i;
      end
   end

   // Lanes beyond the active frame size are forced to zero so the downstream OR-merge stays clean.
   always_comb begin
      lane_count = 32;
      case (sel_q)
         2'd0:    lane_count = 8;
         2'd1:    lane_count = 16;
         default: lane_count = 32;
      endcase
   end

   always_comb begin
      X_R_o = '0;
      X_I_o = '0;
      for (int k = 0; k < MAX_N; k++) begin
         if (k < lane_count) begin
            X_R_o[k*DATA_W +: DATA_W] = mem_r[k];
            X_I_o[k*DATA_W +: DATA_W] = mem_i[k];
         end
      end
   end

endmodule
